// File: rtl/updn_modn_ctr_pkg.sv
// Shared definitions for the up/down modulo-N counter: debounce FSM state
// encodings and a ceil(log2) helper used to size the debounce counter.
package updn_modn_ctr_pkg;

  typedef enum logic [1:0] {
    DB_IDLE   = 2'd0,
    DB_CHK_HI = 2'd1,
    DB_HELD   = 2'd2,
    DB_CHK_LO = 2'd3
  } db_state_e;

  // Minimum of one bit so a counter can always be declared.
  function automatic int ctr_clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/updn_modn_ctr_btn_debounce.sv
// One push-button chain: 2-flop synchroniser, four-state debounce FSM and a
// registered single-cycle press pulse.
module btn_debounce
  import updn_modn_ctr_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW       = ctr_clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_fill;
  logic          r_armed;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_fire;
  logic          r_press;

  logic          w_s;
  db_state_e     w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic          w_fire;

  assign w_s = r_sync[1];

  // A button already held through reset must be seen released before it can
  // start a press; r_fill marks when the synchroniser output is genuine again.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !w_s) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DB_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      DB_IDLE: begin
        if (w_s && r_armed) begin
          w_nxt_state = DB_CHK_HI;
          w_nxt_cnt   = CNT_ONE;
        end else begin
          w_nxt_state = DB_IDLE;
        end
      end
      DB_CHK_HI: begin
        if (!w_s) begin
          w_nxt_state = DB_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_state = DB_HELD;
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end
      DB_HELD: begin
        if (!w_s) begin
          w_nxt_state = DB_CHK_LO;
          w_nxt_cnt   = CNT_ONE;
        end else begin
          w_nxt_state = DB_HELD;
        end
      end
      DB_CHK_LO: begin
        if (w_s) begin
          w_nxt_state = DB_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_state = DB_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nxt_state = DB_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_fire = (r_state == DB_CHK_HI) && w_s && (r_cnt == CNT_LAST);
  end

  // Two register stages put the pulse DEB_CYCLES+3 edges after a clean rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fire  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_fire  <= w_fire;
      r_press <= r_fire;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/updn_modn_ctr.sv
// Up/down modulo-N counter stepped by two debounced push-buttons.
// Optional synchronous load port pair (LOAD, D) when CTR_LOAD_EN is defined.
module updn_modn_ctr
  import updn_modn_ctr_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int MAX        = 5,
  parameter int DEB_CYCLES = 4
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             UP_BUT,
  input  logic             DN_BUT,
`ifdef CTR_LOAD_EN
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
  output logic             UP_P,
  output logic             DN_P
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic             w_up_p;
  logic             w_dn_p;
  logic [WIDTH-1:0] w_nxt_q;
  logic             w_nxt_wrap;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up_deb (
    .i_clk   (C),
    .i_rst_n (RST_N),
    .i_btn   (UP_BUT),
    .o_press (w_up_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn_deb (
    .i_clk   (C),
    .i_rst_n (RST_N),
    .i_btn   (DN_BUT),
    .o_press (w_dn_p)
  );

  always_comb begin
    w_nxt_q    = r_q;
    w_nxt_wrap = 1'b0;
`ifdef CTR_LOAD_EN
    if (LOAD) begin
      w_nxt_q = (D > MAX_V) ? MAX_V : D;
    end else
`endif
    if (w_up_p && !w_dn_p) begin
      if (r_q == MAX_V) begin
        w_nxt_q    = ZERO_V;
        w_nxt_wrap = 1'b1;
      end else begin
        w_nxt_q = r_q + ONE_V;
      end
    end else if (w_dn_p && !w_up_p) begin
      if (r_q == ZERO_V) begin
        w_nxt_q    = MAX_V;
        w_nxt_wrap = 1'b1;
      end else begin
        w_nxt_q = r_q - ONE_V;
      end
    end else begin
      w_nxt_q = r_q;
    end
  end

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      r_q    <= ZERO_V;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_nxt_q;
      r_wrap <= w_nxt_wrap;
    end
  end

  assign Q    = r_q;
  assign WRAP = r_wrap;
  assign UP_P = w_up_p;
  assign DN_P = w_dn_p;

endmodule

// File: tb/tb_updn_modn_ctr.sv
// Directed scoreboard bench for updn_modn_ctr (WIDTH=3, MAX=5, DEB_CYCLES=4).
module tb_updn_modn_ctr;

  logic       C = 1'b0;
  logic       RST_N;
  logic       UP_BUT;
  logic       DN_BUT;
  logic       LOAD;
  logic [2:0] D;
  logic [2:0] Q;
  logic       WRAP;
  logic       UP_P;
  logic       DN_P;

  int total = 0;
  int bad   = 0;
  int mdl_q = 0;
  int wr;

  typedef struct {
    int    n_up;
    int    n_dn;
    int    n_wrap;
    int    q;
    int    up_k;
    int    q_k;
    string tag;
  } exp_t;

  exp_t sb[$];

  always #5 C = ~C;

  updn_modn_ctr #(.WIDTH(3), .MAX(5), .DEB_CYCLES(4)) dut (
    .C      (C),
    .RST_N  (RST_N),
    .UP_BUT (UP_BUT),
    .DN_BUT (DN_BUT),
`ifdef CTR_LOAD_EN
    .LOAD   (LOAD),
    .D      (D),
`endif
    .Q      (Q),
    .WRAP   (WRAP),
    .UP_P   (UP_P),
    .DN_P   (DN_P)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit up, input bit dn, output int wrap_o);
    wrap_o = 0;
    if (up && !dn) begin
      if (mdl_q == 5) begin mdl_q = 0; wrap_o = 1; end
      else mdl_q = mdl_q + 1;
    end else if (dn && !up) begin
      if (mdl_q == 0) begin mdl_q = 5; wrap_o = 1; end
      else mdl_q = mdl_q - 1;
    end
  endtask

  task automatic push(input int n_up, input int n_dn, input int n_wrap, input int up_k,
                      input int q_k, input string tag);
    exp_t e;
    e.n_up = n_up; e.n_dn = n_dn; e.n_wrap = n_wrap; e.q = mdl_q;
    e.up_k = up_k; e.q_k = q_k; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drives a 40-cycle window: 16 patterned cycles, hold to 24, then release.
  task automatic apply(input logic [15:0] up_pat, input logic [15:0] dn_pat,
                       input bit up_hold, input bit dn_hold,
                       input int rst_at, input int load_at, input logic [2:0] load_d);
    int n_up = 0, n_dn = 0, n_wr = 0, up_k = -1, q_k = -1;
    logic [2:0] q0;
    exp_t e;
    q0 = Q;
    for (int k = 1; k <= 40; k++) begin
      UP_BUT = (k <= 16) ? up_pat[k-1] : ((k <= 24) ? up_hold : 1'b0);
      DN_BUT = (k <= 16) ? dn_pat[k-1] : ((k <= 24) ? dn_hold : 1'b0);
      RST_N  = (rst_at >= 0 && k > rst_at && k <= rst_at + 2) ? 1'b0 : 1'b1;
      LOAD   = (k == load_at);
      D      = load_d;
      @(posedge C);
      #1;
      if (UP_P === 1'b1) begin n_up++; if (up_k < 0) up_k = k; end
      if (DN_P === 1'b1) n_dn++;
      if (WRAP === 1'b1) n_wr++;
      if (q_k < 0 && Q !== q0) q_k = k;
    end
    e = sb.pop_front();
    chk({e.tag, "/up_p"}, n_up, e.n_up);
    chk({e.tag, "/dn_p"}, n_dn, e.n_dn);
    chk({e.tag, "/wrap"}, n_wr, e.n_wrap);
    chk({e.tag, "/q"}, Q, e.q);
    if (e.up_k >= 0) begin
      chk({e.tag, "/up_edge"}, up_k, e.up_k);
      chk({e.tag, "/q_edge"}, q_k, e.q_k);
    end
  endtask

  initial begin
    RST_N = 1'b0; UP_BUT = 1'b0; DN_BUT = 1'b0; LOAD = 1'b0; D = 3'd0;

    // Reset held while the buttons toggle.
    for (int i = 0; i < 6; i++) begin
      UP_BUT = i[0];
      DN_BUT = ~i[0];
      @(posedge C);
      #1;
      chk("rst/q", Q, 0);
      chk("rst/wrap", WRAP, 0);
      chk("rst/up_p", UP_P, 0);
      chk("rst/dn_p", DN_P, 0);
    end
    UP_BUT = 1'b0; DN_BUT = 1'b0;
    @(posedge C);
    #1;
    RST_N = 1'b1;
    repeat (6) @(posedge C);
    #1;
    chk("rel/q", Q, 0);

    // First up press with latency check, then five more through the wrap.
    model_step(1'b1, 1'b0, wr);
    push(1, 0, wr, 7, 8, "up1");
    apply(16'hFFFF, 16'h0000, 1'b1, 1'b0, -1, -1, 3'd0);
    for (int n = 2; n <= 6; n++) begin
      model_step(1'b1, 1'b0, wr);
      push(1, 0, wr, -1, -1, $sformatf("up%0d", n));
      apply(16'hFFFF, 16'h0000, 1'b1, 1'b0, -1, -1, 3'd0);
    end

    // Down wrap 0->5, then 5->4.
    for (int n = 1; n <= 2; n++) begin
      model_step(1'b0, 1'b1, wr);
      push(0, 1, wr, -1, -1, $sformatf("dn%0d", n));
      apply(16'h0000, 16'hFFFF, 1'b0, 1'b1, -1, -1, 3'd0);
    end

    // Bouncing rise: 1,0,1,1,0,1,1,1,...
    model_step(1'b1, 1'b0, wr);
    push(1, 0, wr, -1, -1, "bounce");
    apply(16'hFFED, 16'h0000, 1'b1, 1'b0, -1, -1, 3'd0);

    // Short glitches alone.
    push(0, 0, 0, -1, -1, "glitch1");
    apply(16'h0001, 16'h0000, 1'b0, 1'b0, -1, -1, 3'd0);
    push(0, 0, 0, -1, -1, "glitch2");
    apply(16'h0003, 16'h0000, 1'b0, 1'b0, -1, -1, 3'd0);
    push(0, 0, 0, -1, -1, "glitch3");
    apply(16'h0000, 16'h0007, 1'b0, 1'b0, -1, -1, 3'd0);

    // Both buttons together.
    model_step(1'b1, 1'b1, wr);
    push(1, 1, wr, -1, -1, "both");
    apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, -1, -1, 3'd0);

    // Reset two cycles into CHK_HI with the button kept held.
    mdl_q = 0;
    push(0, 0, 0, -1, -1, "midrst");
    apply(16'hFFFF, 16'h0000, 1'b1, 1'b0, 5, -1, 3'd0);

    model_step(1'b1, 1'b0, wr);
    push(1, 0, wr, -1, -1, "fresh");
    apply(16'hFFFF, 16'h0000, 1'b1, 1'b0, -1, -1, 3'd0);

`ifdef CTR_LOAD_EN
    mdl_q = 5;
    push(0, 0, 0, -1, -1, "load7");
    apply(16'h0000, 16'h0000, 1'b0, 1'b0, -1, 3, 3'd7);

    mdl_q = 2;
    push(1, 0, 0, -1, -1, "load2_up");
    apply(16'hFFFF, 16'h0000, 1'b1, 1'b0, -1, 8, 3'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
